// File: rtl/dct_vecrot_prescaling_if.sv
// Stream bundle for the DCT pre-scaler: complex sample sink with frame-length
// side channel, and scaled source carrying sop/eop/error/length tags.
interface dct_vecrot_prescaling_if #(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 36
);
  logic                       sink_valid;
  logic                       sink_ready;
  logic signed [wDataIn-1:0]  sink_real;
  logic signed [wDataIn-1:0]  sink_imag;
  logic [11:0]                fftpts_in;

  logic                       source_valid;
  logic                       source_ready;
  logic                       source_sop;
  logic                       source_eop;
  logic signed [wDataOut-1:0] source_real;
  logic signed [wDataOut-1:0] source_imag;
  logic [1:0]                 source_error;
  logic [11:0]                fftpts_out;

  modport master (
    output sink_valid, sink_real, sink_imag, fftpts_in, source_ready,
    input  sink_ready, source_valid, source_sop, source_eop,
           source_real, source_imag, source_error, fftpts_out
  );

  modport slave (
    input  sink_valid, sink_real, sink_imag, fftpts_in, source_ready,
    output sink_ready, source_valid, source_sop, source_eop,
           source_real, source_imag, source_error, fftpts_out
  );
endinterface

// File: rtl/dct_vecrot_prescaling.sv
// Frames complex samples (sop/eop by latched length) and left-shifts them by 2^16 or 2^17 (2048 pts).
// One-cycle latency, full rate; two-entry output+skid buffer with registered sink_ready.
module dct_vecrot_prescaling #(
  parameter int wDataIn     = 16,
  parameter int wDataOut    = 36,
  parameter int scale_width = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dct_vecrot_prescaling_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic                       sop;
    logic                       eop;
    logic [11:0]                pts;
    logic signed [wDataOut-1:0] re;
    logic signed [wDataOut-1:0] im;
  } ent_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic [1:0]  err_q, err_d;

  ent_t        out_q, out_d;
  ent_t        skd_q, skd_d;
  logic        out_vld_q, out_vld_d;
  logic        skd_vld_q, skd_vld_d;
  logic        rdy_q;

  logic        in_xfer;
  logic        drain;
  logic        keep;
  logic        push;
  logic        legal;
  logic [11:0] cur_len;
  ent_t        new_ent;
  logic signed [wDataOut-1:0] ext_re;
  logic signed [wDataOut-1:0] ext_im;

  assign in_xfer = bus.sink_valid && rdy_q;
  assign drain   = out_vld_q && bus.source_ready;
  assign push    = in_xfer && keep;
  assign legal   = (bus.fftpts_in != 12'd0) && (bus.fftpts_in <= 12'd2048);
  // Length applying to the current sample: live input at frame start, latched afterwards.
  assign cur_len = (state_q == IDLE) ? bus.fftpts_in : len_q;
  assign ext_re  = {{(wDataOut-wDataIn){bus.sink_real[wDataIn-1]}}, bus.sink_real};
  assign ext_im  = {{(wDataOut-wDataIn){bus.sink_imag[wDataIn-1]}}, bus.sink_imag};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_d       = err_q;
    keep        = 1'b0;
    new_ent     = '0;
    new_ent.pts = cur_len;
    if (cur_len == 12'd2048) begin
      new_ent.re = ext_re << (scale_width + 1);
      new_ent.im = ext_im << (scale_width + 1);
    end else begin
      new_ent.re = ext_re << scale_width;
      new_ent.im = ext_im << scale_width;
    end

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (legal) begin
            keep        = 1'b1;
            new_ent.sop = 1'b1;
            len_d       = bus.fftpts_in;
            err_d       = 2'b00;
            if (bus.fftpts_in == 12'd1) begin
              new_ent.eop = 1'b1;
              cnt_d       = 12'd0;
            end else begin
              state_d = RUN;
              cnt_d   = 12'd1;
            end
          end else begin
            err_d = 2'b01;
          end
        end
      end
      RUN: begin
        if (in_xfer) begin
          keep = 1'b1;
          if (cnt_q == len_q - 12'd1) begin
            new_ent.eop = 1'b1;
            cnt_d       = 12'd0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid entry always has priority over a new sample so order is preserved.
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skd_d     = skd_q;
    skd_vld_d = skd_vld_q;
    if (!out_vld_q || drain) begin
      if (skd_vld_q) begin
        out_d     = skd_q;
        out_vld_d = 1'b1;
        skd_vld_d = push;
        if (push) begin
          skd_d = new_ent;
        end
      end else begin
        out_vld_d = push;
        if (push) begin
          out_d = new_ent;
        end
      end
    end else if (push) begin
      skd_d     = new_ent;
      skd_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 2'b00;
      out_q     <= '0;
      skd_q     <= '0;
      out_vld_q <= 1'b0;
      skd_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      out_q     <= out_d;
      skd_q     <= skd_d;
      out_vld_q <= out_vld_d;
      skd_vld_q <= skd_vld_d;
      rdy_q     <= !skd_vld_d;
    end
  end

  assign bus.sink_ready   = rdy_q;
  assign bus.source_valid = out_vld_q;
  assign bus.source_sop   = out_q.sop;
  assign bus.source_eop   = out_q.eop;
  assign bus.source_real  = out_q.re;
  assign bus.source_imag  = out_q.im;
  assign bus.fftpts_out   = out_q.pts;
  assign bus.source_error = err_q;

endmodule

// File: tb/tb_dct_vecrot_prescaling.sv
// Directed bench for dct_vecrot_prescaling: reset, scaling, framing, backpressure, errors.
module tb_dct_vecrot_prescaling;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dct_vecrot_prescaling_if bus ();

  dct_vecrot_prescaling dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [35:0] scl(input int v, input int sh);
    logic signed [35:0] t;
    t = 36'(v);
    return t <<< sh;
  endfunction

  // Streams n back-to-back samples (data base+i) and checks each output one cycle later.
  task automatic run_frame(input string tag, input int len, input int n, input int base,
                           input int sh, input int chg_at);
    int v;
    bus.sink_valid = 1'b1;
    bus.fftpts_in  = 12'(len);
    for (int i = 0; i < n; i++) begin
      v = base + i;
      bus.sink_real = 16'(v);
      bus.sink_imag = 16'(-v);
      if (i == chg_at) bus.fftpts_in = 12'd7;
      chk({tag, "_rdy"}, 36'(bus.sink_ready), 36'd1);
      @(negedge clk);
      chk({tag, "_vld"}, 36'(bus.source_valid), 36'd1);
      chk({tag, "_re"}, bus.source_real, scl(v, sh));
      chk({tag, "_im"}, bus.source_imag, scl(-v, sh));
      chk({tag, "_sop"}, 36'(bus.source_sop), 36'((i % len) == 0));
      chk({tag, "_eop"}, 36'(bus.source_eop), 36'((i % len) == len - 1));
      chk({tag, "_pts"}, 36'(bus.fftpts_out), 36'(len));
    end
    bus.sink_valid = 1'b0;
    bus.fftpts_in  = 12'(len);
    @(negedge clk);
    chk({tag, "_idle_vld"}, 36'(bus.source_valid), 36'd0);
  endtask

  initial begin
    int tx;
    int rx;

    rst_n            = 1'b0;
    bus.sink_valid   = 1'b0;
    bus.sink_real    = '0;
    bus.sink_imag    = '0;
    bus.fftpts_in    = '0;
    bus.source_ready = 1'b1;
    #12;
    chk("rst_sink_ready", 36'(bus.sink_ready), 36'd0);
    chk("rst_valid", 36'(bus.source_valid), 36'd0);
    chk("rst_real", bus.source_real, 36'd0);
    chk("rst_error", 36'(bus.source_error), 36'd0);
    chk("rst_pts", 36'(bus.fftpts_out), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 36'(bus.sink_ready), 36'd1);

    // 2048-point frame: first sample hand-checked, then interrupted by reset at sample 100
    bus.sink_valid = 1'b1;
    bus.fftpts_in  = 12'd2048;
    bus.sink_real  = 16'h0001;
    bus.sink_imag  = 16'hFFFF;
    @(negedge clk);
    chk("f2048_vld0", 36'(bus.source_valid), 36'd1);
    chk("f2048_re0", bus.source_real, 36'h0_0002_0000);
    chk("f2048_im0", bus.source_imag, 36'hF_FFFE_0000);
    chk("f2048_sop0", 36'(bus.source_sop), 36'd1);
    chk("f2048_eop0", 36'(bus.source_eop), 36'd0);
    chk("f2048_pts0", 36'(bus.fftpts_out), 36'd2048);
    for (int k = 1; k <= 100; k++) begin
      bus.sink_real = 16'(k);
      bus.sink_imag = 16'(-k);
      @(negedge clk);
      chk("f2048_re", bus.source_real, scl(k, 17));
      chk("f2048_sop", 36'(bus.source_sop), 36'd0);
    end
    #2;
    rst_n          = 1'b0;
    bus.sink_valid = 1'b0;
    #1;
    chk("arst_valid", 36'(bus.source_valid), 36'd0);
    chk("arst_real", bus.source_real, 36'd0);
    chk("arst_imag", bus.source_imag, 36'd0);
    chk("arst_sop", 36'(bus.source_sop), 36'd0);
    chk("arst_pts", 36'(bus.fftpts_out), 36'd0);
    chk("arst_rdy", 36'(bus.sink_ready), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_arst", 36'(bus.sink_ready), 36'd1);
    run_frame("post_rst", 3, 3, 50, 16, -1);

    // 512 frame, fftpts_in disturbed mid-frame
    run_frame("f512", 512, 512, 0, 16, 5);

    // Backpressure: source_ready low for cycles 3..5
    bus.fftpts_in = 12'd8;
    tx = 0;
    rx = 0;
    for (int c = 0; c < 16; c++) begin
      bus.source_ready = !(c >= 3 && c <= 5);
      if (c == 4) chk("bp_rdy_c4", 36'(bus.sink_ready), 36'd0);
      if (c == 6) chk("bp_rdy_c6", 36'(bus.sink_ready), 36'd0);
      if (c == 7) chk("bp_rdy_c7", 36'(bus.sink_ready), 36'd1);
      if (bus.source_valid) begin
        chk("bp_re", bus.source_real, scl(100 + rx, 16));
        chk("bp_sop", 36'(bus.source_sop), 36'(rx == 0));
        chk("bp_eop", 36'(bus.source_eop), 36'(rx == 7));
        if (bus.source_ready) rx++;
      end
      if (tx < 8) begin
        bus.sink_valid = 1'b1;
        bus.sink_real  = 16'(100 + tx);
        bus.sink_imag  = '0;
        if (bus.sink_ready) tx++;
      end else begin
        bus.sink_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.source_ready = 1'b1;
    bus.sink_valid   = 1'b0;
    chk("bp_count", 36'(rx), 36'd8);

    // Illegal lengths are dropped and flagged
    bus.sink_valid = 1'b1;
    bus.fftpts_in  = 12'd0;
    bus.sink_real  = 16'd9;
    @(negedge clk);
    chk("err0_vld", 36'(bus.source_valid), 36'd0);
    chk("err0_err", 36'(bus.source_error), 36'd1);
    chk("err0_rdy", 36'(bus.sink_ready), 36'd1);
    bus.fftpts_in = 12'd2049;
    @(negedge clk);
    chk("errbig_vld", 36'(bus.source_valid), 36'd0);
    chk("errbig_err", 36'(bus.source_error), 36'd1);
    bus.sink_valid = 1'b0;
    run_frame("after_err", 512, 512, 20, 16, -1);
    chk("err_cleared", 36'(bus.source_error), 36'd0);

    // Length-1 frames: every sample is both sop and eop
    run_frame("len1", 1, 3, 40, 16, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
